lowspeed_host: RTL and testbench
================================

Name: lowspeed_host

Overview:
Command initiator for the lowspeed byte-stream protocol. It takes one command (opcode plus up to 3 argument bytes), serializes it onto a byte stream toward a lowspeed command processor, then collects a fixed number of response bytes and presents them as one word. It is used by on-FPGA self-test and loopback sequencers. It is also used as the bench-side driver for the command processor.

Parameters:
TIMEOUT_CYCLES, 65535, cycles allowed between response bytes before abort; 16-bit counter, valid range 1..65535.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
cmd_valid_i  in  1  command request valid
cmd_ready_o  out  1  high only in IDLE
cmd_opcode_i  in  8  opcode; bits [7:6] = argument byte count (0..3)
cmd_args_i  in  24  arguments; last-sent byte in [7:0]
cmd_resp_len_i  in  2  expected response bytes (0..3)
tx_data_o  out  8  byte to processor
tx_valid_o  out  1  tx byte valid
tx_ready_i  in  1  processor accepts byte
rx_data_i  in  8  byte from processor
rx_valid_i  in  1  rx byte valid
rx_ready_o  out  1  always 1 (rx never stalls)
resp_data_o  out  24  response; first received byte in [7:0], second in [15:8], third in [23:16]; unreceived bytes 0
resp_count_o  out  2  bytes actually received
resp_timeout_o  out  1  this response was aborted by timeout
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
error_timeout_o  out  1  sticky timeout flag
error_stray_o  out  1  sticky: rx byte arrived outside WAIT_RESP

Behaviour:
- States: IDLE, SEND, WAIT_RESP, DONE. One-hot encoding. An illegal state returns to IDLE.
- Reset (reset==0 at a clock edge) forces the following, even mid-command. Any partially sent or partially received command is abandoned.
  - state=IDLE, tx_valid_o=0, resp_valid_o=0, resp_data_o=0, resp_count_o=0, resp_timeout_o=0, both error flags=0, timeout counter=0.
- IDLE: cmd_ready_o=1. On cmd_valid_i&&cmd_ready_o:
  - Latch total = cmd_opcode_i[7:6]+1 bytes to send, and latch resp_len.
  - Load the tx shift register. Bytes go out in this order: opcode, then cmd_args_i[8n-1:8n-8] for n = argcount down to 1, i.e. the most significant argument byte first and [7:0] last.
  - Clear resp_data_o, resp_count_o and resp_timeout_o. Go to SEND.
- SEND: tx_valid_o=1 and tx_data_o = head of the shift register. Both are registered; the first byte appears the cycle after acceptance.
  - On tx_ready_i: shift and decrement the remaining count.
  - After the last byte: if resp_len==0, go to DONE; else go to WAIT_RESP with the timeout counter cleared.
  - tx_data_o must hold stable while tx_valid_o=1 and tx_ready_i=0.
- WAIT_RESP: each rx_valid_i cycle stores rx_data_i into byte lane resp_count_o, increments resp_count_o and clears the timeout counter.
  - When resp_count_o reaches resp_len, go to DONE on that same edge.
  - If no byte arrives, the counter increments each cycle. When it equals TIMEOUT_CYCLES-1 with no byte that cycle, set resp_timeout_o=1 and error_timeout_o=1, then go to DONE with the partial data.
  - A byte arriving on the same cycle as the expiry wins: it is stored and there is no timeout.
- DONE: resp_valid_o=1. On resp_ready_i, go to IDLE. resp_data_o, resp_count_o and resp_timeout_o hold until the next command is accepted. A new command can be accepted no earlier than the cycle after the handshake.
- Stray bytes: rx_valid_i in IDLE, SEND or DONE is discarded and sets error_stray_o. It does not alter resp_data_o. Error flags clear only on reset.
- Latency: minimum for NOOP with resp_len 0 and tx_ready_i tied 1 is:
  - tx byte on cycle +1 after acceptance;
  - resp_valid_o on cycle +2;
  - cmd_ready_o on cycle +3 if resp_ready_i is 1.

Test Plan:
- ECHO2: opcode 0x81, args 0x00ABCD, resp_len 2, tx_ready_i=1 → tx bytes 0x81, 0xAB, 0xCD on consecutive cycles. Reply 0xAB, 0xCD → resp_data_o=0x00CDAB, resp_count_o=2, resp_timeout_o=0.
- NOOP: opcode 0x00, resp_len 0 → single tx byte 0x00. resp_valid_o two cycles after acceptance with resp_data_o=0. With resp_ready_i low for 5 cycles, resp_valid_o stays high and cmd_ready_o stays low.
- Backpressure: ECHO3 opcode 0xC1, args 0x112233, tx_ready_i toggled 1-0-0-1-1-0-1 → bytes 0xC1, 0x11, 0x22, 0x33 each held stable while stalled. None is dropped or duplicated.
- Timeout with TIMEOUT_CYCLES=16: ECHO3 with only one reply byte 0x5A → DONE exactly 16 cycles after that byte, with resp_count_o=1, resp_data_o=0x00005A, resp_timeout_o=1 and error_timeout_o=1. A byte arriving on cycle 16 instead gives count 2 and no timeout.
- Stray: rx_valid_i=1 with data 0x77 while IDLE → error_stray_o=1, resp_data_o unchanged, a subsequent ECHO1 completes normally.
- Reset mid-WAIT_RESP after 1 of 3 bytes → next cycle all outputs at reset values and cmd_ready_o=1. The next ECHO1 of 0x42 returns 0x000042 with count 1.

Source files
------------

// File: rtl/lowspeed_host.sv
// Lowspeed command initiator: serializes opcode+args onto a byte stream, then gathers up to 3 response bytes.
// Latency: first tx byte 1 cycle after accept; tx stalls on tx_ready; response held until resp_ready; rx never stalls.
module lowspeed_host #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [23:0] cmd_args_i,
  input  logic [1:0]  cmd_resp_len_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [23:0] resp_data_o,
  output logic [1:0]  resp_count_o,
  output logic        resp_timeout_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        error_timeout_o,
  output logic        error_stray_o
);

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_SEND = 4'b0010;
  localparam logic [3:0] ST_WAIT = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  state;
  logic [23:0] tx_shift;   // pending argument bytes, next one in [23:16]
  logic [1:0]  tx_left;    // bytes still queued behind the one on tx_data_o
  logic [1:0]  resp_len;
  logic [15:0] tmo_cnt;

  assign cmd_ready_o = (state == ST_IDLE);
  assign rx_ready_o  = 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= ST_IDLE;
      tx_shift        <= 24'd0;
      tx_left         <= 2'd0;
      resp_len        <= 2'd0;
      tmo_cnt         <= 16'd0;
      tx_data_o       <= 8'd0;
      tx_valid_o      <= 1'b0;
      resp_data_o     <= 24'd0;
      resp_count_o    <= 2'd0;
      resp_timeout_o  <= 1'b0;
      resp_valid_o    <= 1'b0;
      error_timeout_o <= 1'b0;
      error_stray_o   <= 1'b0;
    end else begin
      if (rx_valid_i && state != ST_WAIT)
        error_stray_o <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            tx_left        <= cmd_opcode_i[7:6];
            resp_len       <= cmd_resp_len_i;
            tx_data_o      <= cmd_opcode_i;
            tx_valid_o     <= 1'b1;
            resp_data_o    <= 24'd0;
            resp_count_o   <= 2'd0;
            resp_timeout_o <= 1'b0;
            state          <= ST_SEND;
            // Left-justify the used argument bytes so the most significant goes first.
            case (cmd_opcode_i[7:6])
              2'd0:    tx_shift <= 24'd0;
              2'd1:    tx_shift <= {cmd_args_i[7:0], 16'd0};
              2'd2:    tx_shift <= {cmd_args_i[15:0], 8'd0};
              default: tx_shift <= cmd_args_i;
            endcase
          end
        end
        ST_SEND: begin
          if (tx_ready_i) begin
            if (tx_left == 2'd0) begin
              tx_valid_o <= 1'b0;
              tmo_cnt    <= 16'd0;
              if (resp_len == 2'd0) begin
                state        <= ST_DONE;
                resp_valid_o <= 1'b1;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              tx_data_o <= tx_shift[23:16];
              tx_shift  <= {tx_shift[15:0], 8'd0};
              tx_left   <= tx_left - 2'd1;
            end
          end
        end
        ST_WAIT: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (rx_valid_i) begin
            case (resp_count_o)
              2'd0:    resp_data_o[7:0]   <= rx_data_i;
              2'd1:    resp_data_o[15:8]  <= rx_data_i;
              default: resp_data_o[23:16] <= rx_data_i;
            endcase
            resp_count_o <= resp_count_o + 2'd1;
            tmo_cnt      <= 16'd0;
            if (resp_count_o + 2'd1 == resp_len) begin
              state        <= ST_DONE;
              resp_valid_o <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            resp_timeout_o  <= 1'b1;
            error_timeout_o <= 1'b1;
            resp_valid_o    <= 1'b1;
            state           <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          tx_valid_o   <= 1'b0;
          resp_valid_o <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lowspeed_host.sv
// Directed bench for lowspeed_host with a 16-cycle response timeout.
module tb_lowspeed_host;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i;
  logic [23:0] cmd_args_i;
  logic [1:0]  cmd_resp_len_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [23:0] resp_data_o;
  logic [1:0]  resp_count_o;
  logic        resp_timeout_o;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic        error_timeout_o;
  logic        error_stray_o;

  int n_cmp = 0;
  int n_err = 0;

  lowspeed_host #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_args_i(cmd_args_i), .cmd_resp_len_i(cmd_resp_len_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .resp_data_o(resp_data_o), .resp_count_o(resp_count_o), .resp_timeout_o(resp_timeout_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .error_timeout_o(error_timeout_o), .error_stray_o(error_stray_o)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [23:0] args, input logic [1:0] len);
    cmd_valid_i    = 1'b1;
    cmd_opcode_i   = op;
    cmd_args_i     = args;
    cmd_resp_len_i = len;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic ack();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  bit         bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_byte [4] = '{8'hC1, 8'h11, 8'h22, 8'h33};

  initial begin
    int idx;
    reset = 1'b0; cmd_valid_i = 1'b0; cmd_opcode_i = 8'd0; cmd_args_i = 24'd0;
    cmd_resp_len_i = 2'd0; tx_ready_i = 1'b1; rx_data_i = 8'd0; rx_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    tick(); tick();
    reset = 1'b1;

    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_data", 32'(resp_data_o), 32'd0);
    chk("rst_errors", 32'({error_timeout_o, error_stray_o}), 32'd0);
    chk("rx_ready", 32'(rx_ready_o), 32'd1);

    // ECHO2
    issue(8'h81, 24'h00ABCD, 2'd2);
    chk("echo2_busy", 32'(cmd_ready_o), 32'd0);
    chk("echo2_tx0", 32'({tx_valid_o, tx_data_o}), 32'h181);
    tick();
    chk("echo2_tx1", 32'({tx_valid_o, tx_data_o}), 32'h1AB);
    tick();
    chk("echo2_tx2", 32'({tx_valid_o, tx_data_o}), 32'h1CD);
    tick();
    chk("echo2_tx_end", 32'(tx_valid_o), 32'd0);
    reply(8'hAB);
    chk("echo2_mid", 32'(resp_valid_o), 32'd0);
    reply(8'hCD);
    chk("echo2_valid", 32'(resp_valid_o), 32'd1);
    chk("echo2_data", 32'(resp_data_o), 32'h00CDAB);
    chk("echo2_count", 32'(resp_count_o), 32'd2);
    chk("echo2_tmo", 32'(resp_timeout_o), 32'd0);
    ack();
    chk("echo2_idle", 32'({cmd_ready_o, resp_valid_o}), 32'b10);
    chk("echo2_hold", 32'(resp_data_o), 32'h00CDAB);

    // NOOP with held-off response
    issue(8'h00, 24'h000000, 2'd0);
    chk("noop_tx", 32'({tx_valid_o, tx_data_o}), 32'h100);
    chk("noop_clr", 32'(resp_data_o), 32'd0);
    tick();
    chk("noop_valid", 32'(resp_valid_o), 32'd1);
    chk("noop_data", 32'(resp_data_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("noop_stall", 32'({resp_valid_o, cmd_ready_o}), 32'b10);
    end
    ack();
    chk("noop_ready", 32'(cmd_ready_o), 32'd1);

    // ECHO3 under tx backpressure
    issue(8'hC1, 24'h112233, 2'd0);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      tx_ready_i = bp_pat[i];
      chk("bp_valid", 32'(tx_valid_o), 32'd1);
      chk("bp_data", 32'(tx_data_o), 32'(bp_byte[idx]));
      tick();
      if (bp_pat[i]) idx++;
    end
    tx_ready_i = 1'b1;
    chk("bp_end", 32'({tx_valid_o, resp_valid_o}), 32'b01);
    ack();

    // Timeout after one of three bytes
    issue(8'hC1, 24'h010203, 2'd3);
    for (int i = 0; i < 4; i++) tick();
    chk("tmo_sent", 32'(tx_valid_o), 32'd0);
    reply(8'h5A);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_not_yet", 32'(resp_valid_o), 32'd0);
    tick();
    chk("tmo_valid", 32'(resp_valid_o), 32'd1);
    chk("tmo_count", 32'(resp_count_o), 32'd1);
    chk("tmo_data", 32'(resp_data_o), 32'h00005A);
    chk("tmo_flag", 32'({resp_timeout_o, error_timeout_o}), 32'b11);
    ack();

    // Byte on the expiry cycle wins
    issue(8'hC1, 24'h010203, 2'd3);
    for (int i = 0; i < 4; i++) tick();
    reply(8'h5A);
    for (int i = 0; i < 15; i++) tick();
    reply(8'h6B);
    chk("race_wait", 32'({resp_valid_o, resp_timeout_o}), 32'b00);
    chk("race_count", 32'(resp_count_o), 32'd2);
    reply(8'h7C);
    chk("race_done", 32'({resp_valid_o, resp_timeout_o}), 32'b10);
    chk("race_data", 32'(resp_data_o), 32'h7C6B5A);
    ack();

    // Stray byte while idle
    chk("stray_before", 32'(error_stray_o), 32'd0);
    reply(8'h77);
    chk("stray_flag", 32'(error_stray_o), 32'd1);
    chk("stray_data", 32'(resp_data_o), 32'h7C6B5A);
    issue(8'h40, 24'h000099, 2'd1);
    chk("echo1_tx0", 32'(tx_data_o), 32'h40);
    tick();
    chk("echo1_tx1", 32'(tx_data_o), 32'h99);
    tick();
    reply(8'h99);
    chk("echo1_valid", 32'(resp_valid_o), 32'd1);
    chk("echo1_data", 32'({resp_count_o, resp_data_o}), {6'd0, 2'd1, 24'h000099});
    ack();

    // Reset mid-response
    issue(8'hC1, 24'h010203, 2'd3);
    for (int i = 0; i < 4; i++) tick();
    reply(8'h11);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_ready", 32'({cmd_ready_o, tx_valid_o, resp_valid_o}), 32'b100);
    chk("mrst_resp", 32'({resp_timeout_o, resp_count_o, resp_data_o}), 32'd0);
    chk("mrst_err", 32'({error_timeout_o, error_stray_o}), 32'd0);
    issue(8'h40, 24'h000042, 2'd1);
    tick(); tick();
    reply(8'h42);
    chk("post_valid", 32'(resp_valid_o), 32'd1);
    chk("post_data", 32'({resp_count_o, resp_data_o}), {6'd0, 2'd1, 24'h000042});
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
